// File: rtl/div32x32_pkg.sv
// div32x32 shared constants and FSM state type.
// Width and counter sizing live here so the datapath and FSM agree.
package div32x32_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/div32x32_step.sv
// div32x32_step: one combinational radix-2 restoring division step.
// Relies on rem_in < divisor (or divisor == 0), so bit 32 of the difference is the borrow.
module div32x32_step
    import div32x32_pkg::*;
(
    input  logic [DIV_W-1:0] rem_in,
    input  logic             dbit,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] rem_out,
    output logic             q_bit
);

    logic [DIV_W:0] shifted;
    logic [DIV_W:0] diff;

    assign shifted = {rem_in, dbit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[DIV_W];
    assign rem_out = diff[DIV_W] ? shifted[DIV_W-1:0] : diff[DIV_W-1:0];

endmodule

// File: rtl/div32x32.sv
// div32x32: 32-cycle unsigned sequential restoring divider.
// Define DIV32X32_DBZ_EN to add the dbz port and single-cycle divide-by-zero handling.
module div32x32
    import div32x32_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    output logic             busy,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder
`ifdef DIV32X32_DBZ_EN
    ,
    output logic             dbz
`endif
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] rem;
    logic [DIV_W-1:0] dvs;
    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [DIV_W-1:0] work;
    logic [DIV_W-1:0] rem_nxt;
    logic             q_bit;

    div32x32_step u_step (
        .rem_in  (rem),
        .dbit    (work[DIV_W-1]),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            rem       <= '0;
            dvs       <= '0;
            work      <= '0;
`ifdef DIV32X32_DBZ_EN
            dbz       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
`ifdef DIV32X32_DBZ_EN
                        dbz <= (b == '0);
                        if (b == '0) begin
                            quotient  <= '1;
                            remainder <= a;
                        end else begin
`endif
                        work  <= a;
                        dvs   <= b;
                        rem   <= '0;
                        cnt   <= CNT_W'(DIV_W - 1);
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef DIV32X32_DBZ_EN
                        end
`endif
                    end
                end
                RUN: begin
                    rem  <= rem_nxt;
                    work <= {work[DIV_W-2:0], q_bit};
                    if (cnt == '0) begin
                        quotient  <= {work[DIV_W-2:0], q_bit};
                        remainder <= rem_nxt;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32x32.sv
// tb_div32x32: randomized self-checking bench for div32x32.
// Results are compared against native / and % on the sampled operands.
module tb_div32x32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] quotient;
    logic [31:0] remainder;
`ifdef DIV32X32_DBZ_EN
    logic        dbz;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_q  = '0;
    logic [31:0] last_r  = '0;

    always #5 clk = ~clk;

    div32x32 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV32X32_DBZ_EN
        ,
        .dbz       (dbz)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ign >= 0 pulses a bogus start (a=9, b=3) after that many RUN edges.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         input int ign);
        logic [31:0] eq;
        logic [31:0] er;
        int          cyc;
        if (tb_v == 0) begin
            eq = 32'hFFFF_FFFF;
            er = ta;
        end else begin
            eq = ta / tb_v;
            er = ta % tb_v;
        end
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
`ifdef DIV32X32_DBZ_EN
        if (tb_v == 0) begin
            check("dbz_busy", 32'(busy), 32'd0);
            check("dbz_flag", 32'(dbz), 32'd1);
            check("dbz_quot", quotient, eq);
            check("dbz_rem", remainder, er);
            last_q = eq;
            last_r = er;
            return;
        end
`endif
        check("busy_e0", 32'(busy), 32'd1);
        check("hold_quot", quotient, last_q);
        check("hold_rem", remainder, last_r);
        cyc = 0;
        while (busy && cyc < 40) begin
            if (cyc == ign) begin
                start = 1'b1;
                a     = 32'd9;
                b     = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("latency", 32'(cyc), 32'd32);
        check("quot", quotient, eq);
        check("rem", remainder, er);
`ifdef DIV32X32_DBZ_EN
        check("dbz_clr", 32'(dbz), 32'd0);
`endif
        last_q = eq;
        last_r = er;
        if (ign >= 0) begin
            @(posedge clk);
            #1;
            check("ign_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_quot", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
`ifdef DIV32X32_DBZ_EN
        check("rst_dbz", 32'(dbz), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        do_op(32'd7, 32'd2, -1);
        do_op(32'd123, 32'd456, -1);
        do_op(32'hFFFF_FFFF, 32'd1, -1);
        do_op(32'd10000000, 32'd3, -1);
        do_op(32'd100, 32'd7, 10);
        do_op(32'd50, 32'd6, -1);
        do_op(32'hDEAD_BEEF, 32'd13, 31);
        do_op(32'd5, 32'd0, -1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, -1);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20))
                                             : $urandom;
            do_op(ra, rb, -1);
        end

        // Abort a division in flight with an asynchronous reset.
        do_op(32'd999, 32'd4, -1);
        @(negedge clk);
        a     = 32'd1000;
        b     = 32'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_quot", quotient, 32'd0);
        check("abort_rem", remainder, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        last_q = '0;
        last_r = '0;
        do_op(32'd1000, 32'd10, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
